// File: rtl/axi_stream_dw_upsizer_if.sv
// AXI Stream bundle used on both sides of axi_stream_dw_upsizer.
// Zero-width sideband fields collapse to a single bit that is tied off by
// the driver; the upsizer ignores them in that case.
interface axi_stream_dw_upsizer_if #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned IdWidth   = 0,
  parameter int unsigned DestWidth = 0,
  parameter int unsigned UserWidth = 0
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdW       = (IdWidth   > 0) ? IdWidth   : 1;
  localparam int unsigned DestW     = (DestWidth > 0) ? DestWidth : 1;
  localparam int unsigned UserW     = (UserWidth > 0) ? UserWidth : 1;

  logic                 tvalid;
  logic                 tready;
  logic [DataWidth-1:0] tdata;
  logic [StrbWidth-1:0] tstrb;
  logic [StrbWidth-1:0] tkeep;
  logic                 tlast;
  logic [IdW-1:0]       tid;
  logic [DestW-1:0]     tdest;
  logic [UserW-1:0]     tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi_stream_dw_upsizer.sv
// AXI Stream data-width upsizer: packs DataWidthOut/DataWidthIn narrow beats
// into one wide beat, little-endian lane order (first beat in the low lane).
// One narrow beat per cycle is sustained; the closing beat of a word is
// accepted whenever the output register is free or being drained.
// Optional feature macro: AXI_STREAM_DW_UPSIZER_FLUSH_EN
//   defined   -> s_tlast on any lane closes the word early, zero padded
//   undefined -> only the last lane closes a word; early tlast is flagged
module axi_stream_dw_upsizer #(
  parameter int unsigned DataWidthIn  = 8,
  parameter int unsigned DataWidthOut = 64,
  parameter int unsigned IdWidth      = 0,
  parameter int unsigned DestWidth    = 0,
  parameter int unsigned UserWidth    = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  axi_stream_dw_upsizer_if.slave      s,
  axi_stream_dw_upsizer_if.master     m
);

  localparam int unsigned N         = DataWidthOut / DataWidthIn;
  localparam int unsigned StrbIn    = DataWidthIn / 8;
  localparam int unsigned StrbOut   = DataWidthOut / 8;
  localparam int unsigned CntW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdW       = (IdWidth   > 0) ? IdWidth   : 1;
  localparam int unsigned DestW     = (DestWidth > 0) ? DestWidth : 1;
  localparam int unsigned UserW     = (UserWidth > 0) ? UserWidth : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(N - 1);

  // Reject configurations the lane arithmetic cannot represent.
  if (DataWidthOut % DataWidthIn != 0) begin : g_err_ratio
    $error("DataWidthOut must be an integer multiple of DataWidthIn");
  end
  if (DataWidthOut <= DataWidthIn) begin : g_err_wider
    $error("DataWidthOut must be wider than DataWidthIn");
  end
  if (DataWidthIn % 8 != 0) begin : g_err_bytes
    $error("DataWidthIn must be a multiple of 8");
  end

  // Accumulator (stage p0) and output register (stage p1).
  logic [CntW-1:0]         cnt_q;
  logic [DataWidthOut-1:0] acc_data_p0;
  logic [StrbOut-1:0]      acc_strb_p0;
  logic [StrbOut-1:0]      acc_keep_p0;
  logic [IdW-1:0]          acc_id_p0;
  logic [DestW-1:0]        acc_dest_p0;
  logic [UserW-1:0]        acc_user_p0;

  logic                    vld_p1;
  logic [DataWidthOut-1:0] data_p1;
  logic [StrbOut-1:0]      strb_p1;
  logic [StrbOut-1:0]      keep_p1;
  logic                    last_p1;
  logic [IdW-1:0]          id_p1;
  logic [DestW-1:0]        dest_p1;
  logic [UserW-1:0]        user_p1;

  // Accumulator with the current narrow beat merged into lane cnt_q.
  logic [DataWidthOut-1:0] mrg_data;
  logic [StrbOut-1:0]      mrg_strb;
  logic [StrbOut-1:0]      mrg_keep;
  logic [IdW-1:0]          mrg_id;
  logic [DestW-1:0]        mrg_dest;
  logic [UserW-1:0]        mrg_user;

  logic out_free;
  logic last_lane;
  logic closing;
  logic s_fire;

  assign out_free  = !vld_p1 || m.tready;
  assign last_lane = (cnt_q == LastLane);
`ifdef AXI_STREAM_DW_UPSIZER_FLUSH_EN
  assign closing   = last_lane || s.tlast;
`else
  assign closing   = last_lane;
`endif
  // Only the closing beat needs room in the output register.
  assign s.tready  = closing ? out_free : 1'b1;
  assign s_fire    = s.tvalid && s.tready;

  // Merge the incoming beat into its lane; lanes above cnt_q are still zero.
  always_comb begin
    mrg_data = acc_data_p0;
    mrg_strb = acc_strb_p0;
    mrg_keep = acc_keep_p0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CntW'(i)) begin
        mrg_data[i*DataWidthIn +: DataWidthIn] = s.tdata;
        mrg_strb[i*StrbIn +: StrbIn]           = s.tstrb;
        mrg_keep[i*StrbIn +: StrbIn]           = s.tkeep;
      end
    end
    mrg_id   = '0;
    mrg_dest = '0;
    mrg_user = '0;
    if (IdWidth > 0)   mrg_id   = (cnt_q == '0) ? s.tid   : acc_id_p0;
    if (DestWidth > 0) mrg_dest = (cnt_q == '0) ? s.tdest : acc_dest_p0;
    if (UserWidth > 0) mrg_user = (cnt_q == '0) ? s.tuser : acc_user_p0;
  end

  // ---- stage p0: lane counter and accumulator ----
  // Advance the lane counter and accumulate; clear everything on a close.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      acc_data_p0 <= '0;
      acc_strb_p0 <= '0;
      acc_keep_p0 <= '0;
      acc_id_p0   <= '0;
      acc_dest_p0 <= '0;
      acc_user_p0 <= '0;
    end else if (s_fire) begin
      if (closing) begin
        cnt_q       <= '0;
        acc_data_p0 <= '0;
        acc_strb_p0 <= '0;
        acc_keep_p0 <= '0;
        acc_id_p0   <= '0;
        acc_dest_p0 <= '0;
        acc_user_p0 <= '0;
      end else begin
        cnt_q       <= cnt_q + CntW'(1);
        acc_data_p0 <= mrg_data;
        acc_strb_p0 <= mrg_strb;
        acc_keep_p0 <= mrg_keep;
        acc_id_p0   <= mrg_id;
        acc_dest_p0 <= mrg_dest;
        acc_user_p0 <= mrg_user;
      end
    end
  end

  // ---- stage p1: registered wide output ----
  // Load on a closing accept (even while draining), else drop valid on ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      strb_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
      id_p1   <= '0;
      dest_p1 <= '0;
      user_p1 <= '0;
    end else if (s_fire && closing) begin
      vld_p1  <= 1'b1;
      data_p1 <= mrg_data;
      strb_p1 <= mrg_strb;
      keep_p1 <= mrg_keep;
      last_p1 <= s.tlast;
      id_p1   <= mrg_id;
      dest_p1 <= mrg_dest;
      user_p1 <= mrg_user;
    end else if (m.tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m.tvalid = vld_p1;
  assign m.tdata  = data_p1;
  assign m.tstrb  = strb_p1;
  assign m.tkeep  = keep_p1;
  assign m.tlast  = last_p1;
  assign m.tid    = id_p1;
  assign m.tdest  = dest_p1;
  assign m.tuser  = user_p1;

  // Flag producer protocol errors; the datapath takes no action on them.
  always_ff @(posedge clk_i) begin
    if (rst_ni && s_fire && (cnt_q != '0)) begin
      assert ((IdWidth == 0 || s.tid == acc_id_p0) &&
              (DestWidth == 0 || s.tdest == acc_dest_p0))
        else $error("tid/tdest changed inside one wide word");
    end
`ifndef AXI_STREAM_DW_UPSIZER_FLUSH_EN
    if (rst_ni && s_fire) begin
      assert (!(s.tlast && !last_lane))
        else $error("s_tlast on a non-final lane without flush support");
    end
`endif
  end

endmodule
